lsu_addr_router: RTL and testbench

//  Parametrised LSU request router: decodes a target select, forwards one registered

---
 rtl/lsu_addr_router_if.sv | 39 +++
 rtl/lsu_addr_router.sv | 179 +++++++++++++++++
 tb/tb_lsu_addr_router.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_addr_router_if.sv
// LSU-side request/response and target-side bus bundle for lsu_addr_router.
// slave = router view, master = the surrounding LSU plus targets.
interface lsu_addr_router_if #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int NUM_TGT = 3,
    parameter int SEL_W   = $clog2(NUM_TGT)
);
    logic                             req_valid;
    logic                             req_ready;
    logic [SEL_W-1:0]                 req_sel;
    logic [ADDR_W-1:0]                req_addr;
    logic                             req_we;
    logic [DATA_W-1:0]                req_wdata;
    logic [NUM_TGT-1:0]               tgt_valid;
    logic [NUM_TGT-1:0]               tgt_ready;
    logic [NUM_TGT-1:0][ADDR_W-1:0]   tgt_addr;
    logic                             tgt_we;
    logic [DATA_W-1:0]                tgt_wdata;
    logic [NUM_TGT-1:0]               tgt_rvalid;
    logic [NUM_TGT-1:0][DATA_W-1:0]   tgt_rdata;
    logic                             rsp_valid;
    logic [DATA_W-1:0]                rsp_rdata;
    logic                             rsp_err;

    modport slave (
        input  req_valid, req_sel, req_addr, req_we, req_wdata,
        input  tgt_ready, tgt_rvalid, tgt_rdata,
        output req_ready, tgt_valid, tgt_addr, tgt_we, tgt_wdata,
        output rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_sel, req_addr, req_we, req_wdata,
        output tgt_ready, tgt_rvalid, tgt_rdata,
        input  req_ready, tgt_valid, tgt_addr, tgt_we, tgt_wdata,
        input  rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_addr_router.sv
// LSU request router: one registered request to one of NUM_TGT targets, one response back.
// Optional response watchdog enabled by defining LSU_ROUTER_TIMEOUT_EN.

module lsu_addr_router_slot #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 2,
    parameter int IDX    = 0
) (
    input  logic              issue,
    input  logic [SEL_W-1:0]  sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic              ready,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    output logic              valid,
    output logic [ADDR_W-1:0] tgt_addr,
    output logic              sel_ready,
    output logic              sel_rvalid,
    output logic [DATA_W-1:0] sel_rdata
);
    logic hit;

    // Handshakes from a target we are not talking to are masked here.
    assign hit        = (sel == SEL_W'(IDX));
    assign valid      = issue & hit;
    assign tgt_addr   = valid ? addr : '0;
    assign sel_ready  = hit & ready;
    assign sel_rvalid = hit & rvalid;
    assign sel_rdata  = hit ? rdata : '0;
endmodule

module lsu_addr_router #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int NUM_TGT     = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    lsu_addr_router_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_TGT);
    localparam logic [SEL_W:0] NUM_TGT_L = (SEL_W+1)'(NUM_TGT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                accept, sel_ok, issue, tmo;
    logic                sel_ready, sel_rvalid;
    logic [DATA_W-1:0]   sel_rdata;

    logic [NUM_TGT-1:0]             valid_v, sel_ready_v, sel_rvalid_v;
    logic [NUM_TGT-1:0][ADDR_W-1:0] addr_v;
    logic [NUM_TGT-1:0][DATA_W-1:0] sel_rdata_v;

    assign bus.req_ready = rst_ni & (state_q == IDLE);
    assign accept        = bus.req_valid & bus.req_ready;
    assign sel_ok        = ({1'b0, bus.req_sel} < NUM_TGT_L);
    assign issue         = (state_q == ISSUE);

    for (genvar i = 0; i < NUM_TGT; i++) begin : g_tgt
        lsu_addr_router_slot #(
            .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .IDX(i)
        ) u_slot (
            .issue     (issue),
            .sel       (sel_q),
            .addr      (addr_q),
            .ready     (bus.tgt_ready[i]),
            .rvalid    (bus.tgt_rvalid[i]),
            .rdata     (bus.tgt_rdata[i]),
            .valid     (valid_v[i]),
            .tgt_addr  (addr_v[i]),
            .sel_ready (sel_ready_v[i]),
            .sel_rvalid(sel_rvalid_v[i]),
            .sel_rdata (sel_rdata_v[i])
        );
    end

    assign sel_ready  = |sel_ready_v;
    assign sel_rvalid = |sel_rvalid_v;

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_TGT; i++) sel_rdata = sel_rdata | sel_rdata_v[i];
    end

    assign bus.tgt_valid = valid_v;
    assign bus.tgt_addr  = addr_v;
    assign bus.tgt_we    = we_q;
    assign bus.tgt_wdata = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

`ifdef LSU_ROUTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC+1);
    logic [CNT_W-1:0] cnt_q;

    // Counter sits at zero in IDLE, so it is clear on every entry to ISSUE.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)                cnt_q <= '0;
        else if (state_q == IDLE)   cnt_q <= '0;
        else                        cnt_q <= cnt_q + CNT_W'(1);
    end
    assign tmo = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYC-1));
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (accept && sel_ok) begin
                    state_d = ISSUE;
                end else if (accept) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            ISSUE: begin
                // A real completion in the last watchdog cycle beats the timeout.
                if (sel_ready && we_q) begin
                    state_d = IDLE; rsp_valid_d = 1'b1; rsp_err_d = 1'b0; rsp_rdata_d = '0;
                end else if (sel_ready && sel_rvalid) begin
                    state_d = IDLE; rsp_valid_d = 1'b1; rsp_err_d = 1'b0; rsp_rdata_d = sel_rdata;
                end else if (tmo) begin
                    state_d = IDLE; rsp_valid_d = 1'b1; rsp_err_d = 1'b1; rsp_rdata_d = '0;
                end else if (sel_ready) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (sel_rvalid) begin
                    state_d = IDLE; rsp_valid_d = 1'b1; rsp_err_d = 1'b0; rsp_rdata_d = sel_rdata;
                end else if (tmo) begin
                    state_d = IDLE; rsp_valid_d = 1'b1; rsp_err_d = 1'b1; rsp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (accept) begin
                sel_q   <= bus.req_sel;
                addr_q  <= bus.req_addr;
                we_q    <= bus.req_we;
                wdata_q <= bus.req_wdata;
            end
        end
    end
endmodule

// File: tb/tb_lsu_addr_router.sv
// Scoreboard bench for lsu_addr_router: expected responses are queued at request time
// and popped when rsp_valid pulses; outputs sampled on the falling edge.
module tb_lsu_addr_router;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int NUM_TGT = 3;
`ifdef LSU_ROUTER_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    logic clk   = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    lsu_addr_router_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_TGT(NUM_TGT)) bus ();

    lsu_addr_router #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_TGT(NUM_TGT), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    task automatic drive_idle();
        bus.req_valid  = 1'b0;
        bus.req_sel    = '0;
        bus.req_addr   = '0;
        bus.req_we     = 1'b0;
        bus.req_wdata  = '0;
        bus.tgt_ready  = '0;
        bus.tgt_rvalid = '0;
        bus.tgt_rdata  = '0;
    endtask

    task automatic issue_req(input logic [1:0] sel, input logic [ADDR_W-1:0] addr,
                             input logic we, input logic [DATA_W-1:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_sel   = sel;
        bus.req_addr  = addr;
        bus.req_we    = we;
        bus.req_wdata = wdata;
    endtask

    task automatic wait_rsp(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready: got %b want 0", bus.req_ready);
        end
        total++;
        if ({bus.tgt_valid, bus.tgt_addr, bus.tgt_we, bus.tgt_wdata,
             bus.rsp_valid, bus.rsp_rdata, bus.rsp_err} !== '0) begin
            bad++; $display("FAIL reset_outputs: valid=%b addr=%h rsp=%b err=%b want all 0",
                            bus.tgt_valid, bus.tgt_addr, bus.rsp_valid, bus.rsp_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready: got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_write();
        logic [NUM_TGT-1:0][ADDR_W-1:0] ea;
        exp_t e;
        issue_req(2'd1, 12'h804, 1'b1, 32'hDEADBEEF);
        bus.tgt_ready = 3'b010;
        sbq.push_back('{32'h0, 1'b0});
        @(negedge clk);
        bus.req_valid = 1'b0;
        ea = '0; ea[1] = 12'h804;
        total++;
        if (bus.tgt_valid !== 3'b010 || bus.tgt_addr !== ea) begin
            bad++; $display("FAIL write_issue: valid=%b addr=%h want 010 %h", bus.tgt_valid, bus.tgt_addr, ea);
        end
        total++;
        if (bus.tgt_we !== 1'b1 || bus.tgt_wdata !== 32'hDEADBEEF || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
            bad++; $display("FAIL write_bus: we=%b wdata=%h rsp=%b rdy=%b want 1 deadbeef 0 0",
                            bus.tgt_we, bus.tgt_wdata, bus.rsp_valid, bus.req_ready);
        end
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.tgt_valid !== 3'b000) begin
            bad++; $display("FAIL write_rsp_latency: rsp=%b valid=%b want 1 000", bus.rsp_valid, bus.tgt_valid);
        end
        e = sbq.pop_front();
        total++;
        if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
            bad++; $display("FAIL write_rsp_data: rdata=%h err=%b want %h %b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
        end
        bus.tgt_ready = '0;
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL write_rsp_pulse: rsp=%b want 0", bus.rsp_valid);
        end
    endtask

    task automatic test_read_stall();
        logic [NUM_TGT-1:0][ADDR_W-1:0] ea;
        exp_t e;
        issue_req(2'd0, 12'h07C, 1'b0, 32'h0);
        sbq.push_back('{32'h1234, 1'b0});
        ea = '0; ea[0] = 12'h07C;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (bus.tgt_valid !== 3'b001 || bus.tgt_addr !== ea || bus.tgt_we !== 1'b0) begin
                bad++; $display("FAIL read_stall_hold%0d: valid=%b addr=%h we=%b want 001 %h 0",
                                i, bus.tgt_valid, bus.tgt_addr, bus.tgt_we, ea);
            end
            if (i == 0) @(negedge clk);
        end
        bus.tgt_ready = 3'b001;
        @(negedge clk);
        bus.tgt_ready = '0;
        total++;
        if (bus.tgt_valid !== 3'b000 || bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL read_wait_state: valid=%b rsp=%b want 000 0", bus.tgt_valid, bus.rsp_valid);
        end
        repeat (2) @(negedge clk);
        bus.tgt_rvalid   = 3'b001;
        bus.tgt_rdata[0] = 32'h1234;
        @(negedge clk);
        bus.tgt_rvalid = '0;
        bus.tgt_rdata  = '0;
        e = sbq.pop_front();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
            bad++; $display("FAIL read_rsp: rsp=%b rdata=%h err=%b want 1 %h %b",
                            bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
        end
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h1234) begin
            bad++; $display("FAIL read_rsp_hold: rsp=%b rdata=%h want 0 00001234", bus.rsp_valid, bus.rsp_rdata);
        end
    endtask

    task automatic test_read_same_cycle();
        exp_t e;
        issue_req(2'd2, 12'h0FF, 1'b0, 32'h0);
        sbq.push_back('{32'h55AA, 1'b0});
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.tgt_ready    = 3'b100;
        bus.tgt_rvalid   = 3'b100;
        bus.tgt_rdata[2] = 32'h55AA;
        @(negedge clk);
        bus.tgt_ready = '0; bus.tgt_rvalid = '0; bus.tgt_rdata = '0;
        e = sbq.pop_front();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
            bad++; $display("FAIL read_direct: rsp=%b rdata=%h err=%b want 1 %h %b",
                            bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
        end
        @(negedge clk);
    endtask

    task automatic test_bad_sel();
        exp_t e;
        issue_req(2'd3, 12'h123, 1'b1, 32'hCAFE);
        bus.tgt_ready = 3'b111;
        sbq.push_back('{32'h0, 1'b1});
        @(negedge clk);
        bus.req_valid = 1'b0;
        e = sbq.pop_front();
        total++;
        if (bus.tgt_valid !== 3'b000 || bus.req_ready !== 1'b1) begin
            bad++; $display("FAIL badsel_no_issue: valid=%b rdy=%b want 000 1", bus.tgt_valid, bus.req_ready);
        end
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== e.err || bus.rsp_rdata !== e.rdata) begin
            bad++; $display("FAIL badsel_rsp: rsp=%b err=%b rdata=%h want 1 %b %h",
                            bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, e.err, e.rdata);
        end
        @(negedge clk);
        bus.tgt_ready = '0;
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.tgt_valid !== 3'b000) begin
            bad++; $display("FAIL badsel_after: rsp=%b valid=%b want 0 000", bus.rsp_valid, bus.tgt_valid);
        end
    endtask

    task automatic test_spurious();
        exp_t e;
        issue_req(2'd0, 12'h010, 1'b0, 32'h0);
        sbq.push_back('{32'hA5A5A5A5, 1'b0});
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.tgt_ready    = 3'b100;
        bus.tgt_rvalid   = 3'b100;
        bus.tgt_rdata[2] = 32'hFFFF0000;
        @(negedge clk);
        total++;
        if (bus.tgt_valid !== 3'b001 || bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL spurious_ready: valid=%b rsp=%b want 001 0", bus.tgt_valid, bus.rsp_valid);
        end
        bus.tgt_ready = 3'b001;
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.tgt_valid !== 3'b000) begin
            bad++; $display("FAIL spurious_rvalid: rsp=%b valid=%b want 0 000", bus.rsp_valid, bus.tgt_valid);
        end
        bus.tgt_ready    = '0;
        bus.tgt_rvalid   = 3'b101;
        bus.tgt_rdata[0] = 32'hA5A5A5A5;
        @(negedge clk);
        bus.tgt_rvalid = '0; bus.tgt_rdata = '0;
        e = sbq.pop_front();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
            bad++; $display("FAIL spurious_data: rsp=%b rdata=%h err=%b want 1 %h %b",
                            bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [NUM_TGT-1:0][ADDR_W-1:0] ea;
        exp_t e;
        issue_req(2'd0, 12'h0AA, 1'b1, 32'h1111);
        bus.tgt_ready = 3'b111;
        sbq.push_back('{32'h0, 1'b0});
        @(negedge clk);
        issue_req(2'd2, 12'h0BB, 1'b1, 32'h2222);
        sbq.push_back('{32'h0, 1'b0});
        total++;
        if (bus.req_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_busy: rdy=%b want 0", bus.req_ready);
        end
        @(negedge clk);
        e = sbq.pop_front();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b1 || bus.rsp_err !== e.err || bus.rsp_rdata !== e.rdata) begin
            bad++; $display("FAIL b2b_first_rsp: rsp=%b rdy=%b err=%b rdata=%h want 1 1 %b %h",
                            bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.rsp_rdata, e.err, e.rdata);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        ea = '0; ea[2] = 12'h0BB;
        total++;
        if (bus.tgt_valid !== 3'b100 || bus.tgt_addr !== ea || bus.tgt_wdata !== 32'h2222) begin
            bad++; $display("FAIL b2b_second_issue: valid=%b addr=%h wdata=%h want 100 %h 00002222",
                            bus.tgt_valid, bus.tgt_addr, bus.tgt_wdata, ea);
        end
        @(negedge clk);
        bus.tgt_ready = '0;
        e = sbq.pop_front();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== e.err || bus.rsp_rdata !== e.rdata) begin
            bad++; $display("FAIL b2b_second_rsp: rsp=%b err=%b rdata=%h want 1 %b %h",
                            bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, e.err, e.rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   got;
        issue_req(2'd1, 12'h0C0, 1'b0, 32'h0);
        bus.tgt_ready = 3'b010;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.tgt_ready = '0;
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.req_ready, bus.tgt_valid, bus.tgt_addr, bus.tgt_we, bus.tgt_wdata,
             bus.rsp_valid, bus.rsp_rdata, bus.rsp_err} !== '0) begin
            bad++; $display("FAIL midreset_outputs: rdy=%b valid=%b rsp=%b want all 0",
                            bus.req_ready, bus.tgt_valid, bus.rsp_valid);
        end
        bus.tgt_rvalid   = 3'b010;
        bus.tgt_rdata[1] = 32'hDEAD;
        @(negedge clk);
        rst_n = 1'b1;
        bus.tgt_rvalid = '0; bus.tgt_rdata = '0;
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL midreset_no_rsp: rsp=%b rdy=%b rdata=%h want 0 1 0",
                            bus.rsp_valid, bus.req_ready, bus.rsp_rdata);
        end
        issue_req(2'd1, 12'h0C4, 1'b0, 32'h0);
        bus.tgt_ready    = 3'b010;
        bus.tgt_rvalid   = 3'b010;
        bus.tgt_rdata[1] = 32'h77;
        sbq.push_back('{32'h77, 1'b0});
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_rsp(5, got);
        bus.tgt_ready = '0; bus.tgt_rvalid = '0; bus.tgt_rdata = '0;
        e = sbq.pop_front();
        total++;
        if (!got) begin
            bad++; $display("FAIL postreset_read: no rsp within 5 cycles, want rdata %h", e.rdata);
        end else if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
            bad++; $display("FAIL postreset_read: rdata=%h err=%b want %h %b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
        end
        @(negedge clk);
    endtask

`ifdef LSU_ROUTER_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        issue_req(2'd0, 12'h001, 1'b1, 32'h0);
        sbq.push_back('{32'h0, 1'b1});
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (TMO-1) @(negedge clk);
        total++;
        if (bus.tgt_valid !== 3'b001 || bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL timeout_early: valid=%b rsp=%b want 001 0", bus.tgt_valid, bus.rsp_valid);
        end
        @(negedge clk);
        bus.tgt_rvalid = 3'b001;
        e = sbq.pop_front();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== e.err || bus.rsp_rdata !== e.rdata || bus.tgt_valid !== 3'b000) begin
            bad++; $display("FAIL timeout_rsp: rsp=%b err=%b rdata=%h valid=%b want 1 1 0 000",
                            bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.tgt_valid);
        end
        @(negedge clk);
        bus.tgt_rvalid = '0;
        total++;
        if (bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL timeout_late_rvalid: rsp=%b want 0", bus.rsp_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read_stall();
        test_read_same_cycle();
        test_bad_sel();
        test_spurious();
        test_back_to_back();
        test_reset_mid();
`ifdef LSU_ROUTER_TIMEOUT_EN
        test_timeout();
`endif
        total++;
        if (sbq.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: %0d left want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
